// File: rtl/gray_seg_scan_driver_if.sv
// Display-side bundle for gray_seg_scan_driver: digit codes and load strobe in,
// registered cathode/anode drive and scan index out.
interface gray_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] code_in;
  logic                    gray_mode;
  logic                    load;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IDXW-1:0]         digit_idx;

  modport master (
    output code_in, gray_mode, load,
    input  seg_n, dp_n, an_n, digit_idx
  );

  modport slave (
    input  code_in, gray_mode, load,
    output seg_n, dp_n, an_n, digit_idx
  );
endinterface

// File: rtl/gray_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with Gray/binary nibble decode.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module gray_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                   clk,
  input logic                   rst_n,
  gray_seg_scan_driver_if.slave bus
);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [CNTW-1:0]         cnt_reg, cnt_next;
  logic [IDXW-1:0]         digit_idx_reg, digit_idx_next;
  logic [4*NUM_DIGITS-1:0] data_reg;
  logic                    mode_reg;
  logic                    first_reg;
  logic [NUM_DIGITS-1:0]   an_n_reg;
  logic [6:0]              seg_n_reg;
  logic                    dp_n_reg;

  logic [4*NUM_DIGITS-1:0] src_data;
  logic                    src_mode;
  logic [3:0]              val [NUM_DIGITS];
  logic [3:0]              cur_val;
  logic                    blank_lz;

  function automatic logic [3:0] to_bin(input logic [3:0] g, input logic gm);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return gm ? b : g;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [3:0] d;
    d = (v > 4'd9) ? v - 4'd10 : v;
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  // On the very first edge after reset a simultaneous load is shown immediately.
  assign src_data = (first_reg && bus.load) ? bus.code_in   : data_reg;
  assign src_mode = (first_reg && bus.load) ? bus.gray_mode : mode_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      assign val[gi] = to_bin(src_data[4*gi +: 4], src_mode);
    end
  endgenerate

  always_comb begin
    cur_val = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx_reg == IDXW'(k)) cur_val = val[k];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[k]: digit k and every higher digit decode to 0.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign zero_from[gi] = (val[gi] == 4'd0);
      end else begin : g_mid
        assign zero_from[gi] = (val[gi] == 4'd0) && zero_from[gi+1];
      end
    end
  endgenerate

  always_comb begin
    blank_lz = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (digit_idx_reg == IDXW'(k)) blank_lz = zero_from[k];
    end
  end
`else
  assign blank_lz = 1'b0;
`endif

  assign cnt_next       = (cnt_reg == CNTW'(REFRESH_DIV - 1)) ? '0 : cnt_reg + 1'b1;
  assign digit_idx_next = (digit_idx_reg == IDXW'(NUM_DIGITS - 1)) ? '0 : digit_idx_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      digit_idx_reg <= '0;
      data_reg      <= '0;
      mode_reg      <= 1'b0;
      first_reg     <= 1'b1;
      an_n_reg      <= '1;
      seg_n_reg     <= 7'h7F;
      dp_n_reg      <= 1'b1;
    end else begin
      first_reg <= 1'b0;
      if (bus.load) begin
        data_reg <= bus.code_in;
        mode_reg <= bus.gray_mode;
      end
      cnt_reg <= cnt_next;
      if (cnt_next == '0) begin
        // Blanking cycle between digits suppresses ghosting while anodes switch.
        digit_idx_reg <= digit_idx_next;
        an_n_reg      <= '1;
        seg_n_reg     <= 7'h7F;
        dp_n_reg      <= 1'b1;
      end else begin
        an_n_reg <= ~(AN_ONE << digit_idx_reg);
        if (blank_lz) begin
          seg_n_reg <= 7'h7F;
          dp_n_reg  <= 1'b1;
        end else begin
          seg_n_reg <= seg_of(cur_val);
          dp_n_reg  <= (cur_val < 4'd10);
        end
      end
    end
  end

  assign bus.seg_n     = seg_n_reg;
  assign bus.dp_n      = dp_n_reg;
  assign bus.an_n      = an_n_reg;
  assign bus.digit_idx = digit_idx_reg;
endmodule

// File: tb/tb_gray_seg_scan_driver.sv
// Directed bench for gray_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_gray_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  gray_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  gray_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'b0000001;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.code_in = '0; bus.gray_mode = 1'b0; bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",  32'(bus.an_n), 32'hF);
    chk("rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("rst_dp",  32'(bus.dp_n), 32'h1);
    chk("rst_idx", 32'(bus.digit_idx), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    step(1);  // edge 1
    chk("e1_an",  32'(bus.an_n), 32'b1110);
    chk("e1_seg", 32'(bus.seg_n), 32'b0000001);
    chk("e1_dp",  32'(bus.dp_n), 32'h1);
    step(3);  // edge 4
    chk("e4_an",  32'(bus.an_n), 32'b1111);
    chk("e4_seg", 32'(bus.seg_n), 32'h7F);
    chk("e4_idx", 32'(bus.digit_idx), 32'h1);
    step(1);  // edge 5
    chk("e5_an",  32'(bus.an_n), 32'b1101);
    chk("e5_seg", 32'(bus.seg_n), 32'(LZ_SEG));
    step(8);  // edge 13
    chk("e13_an", 32'(bus.an_n), 32'b0111);
    step(4);  // edge 17
    chk("e17_an", 32'(bus.an_n), 32'b1110);
    chk("e17_idx", 32'(bus.digit_idx), 32'h0);

    bus.code_in = 16'h0C13; bus.gray_mode = 1'b1; bus.load = 1'b1;
    step(1);  // edge 18: capture only
    bus.load = 1'b0;
    chk("gray_lat", 32'(bus.seg_n), 32'b0000001);
    step(1);  // edge 19
    chk("gray_d0",  32'(bus.seg_n), 32'b0010010);
    chk("gray_dp0", 32'(bus.dp_n), 32'h1);
    step(2);  // edge 21
    chk("gray_an1", 32'(bus.an_n), 32'b1101);
    chk("gray_d1",  32'(bus.seg_n), 32'b1001111);
    step(4);  // edge 25
    chk("gray_an2", 32'(bus.an_n), 32'b1011);
    chk("gray_d2",  32'(bus.seg_n), 32'b0000000);
    step(4);  // edge 29
    chk("gray_d3",  32'(bus.seg_n), 32'(LZ_SEG));

    step(4);  // edge 33, digit 0 lit
    bus.code_in = 16'h000F; bus.gray_mode = 1'b0; bus.load = 1'b1;
    step(1);  // edge 34
    bus.load = 1'b0;
    step(1);  // edge 35
    chk("bin_d0", 32'(bus.seg_n), 32'b0100100);
    chk("bin_dp", 32'(bus.dp_n), 32'h0);
    bus.gray_mode = 1'b1; bus.load = 1'b1;
    step(1);  // edge 36: wrap and capture
    bus.load = 1'b0;
    chk("wrap_seg", 32'(bus.seg_n), 32'h7F);
    chk("wrap_dp",  32'(bus.dp_n), 32'h1);
    chk("wrap_an",  32'(bus.an_n), 32'b1111);
    step(1);  // edge 37, digit 1
    chk("ovf_d1",    32'(bus.seg_n), 32'(LZ_SEG));
    chk("ovf_d1_dp", 32'(bus.dp_n), 32'h1);
    step(12); // edge 49, digit 0
    chk("ovf_d0",    32'(bus.seg_n), 32'b0000001);
    chk("ovf_dp",    32'(bus.dp_n), 32'h0);

    bus.code_in = 16'h0001; bus.gray_mode = 1'b0; bus.load = 1'b1;
    step(1);  // edge 50: capture at cnt=2
    bus.load = 1'b0;
    chk("mid_old", 32'(bus.seg_n), 32'b0000001);
    step(1);  // edge 51
    chk("mid_seg", 32'(bus.seg_n), 32'b1001111);
    chk("mid_dp",  32'(bus.dp_n), 32'h1);
    chk("mid_an",  32'(bus.an_n), 32'b1110);
    chk("mid_idx", 32'(bus.digit_idx), 32'h0);
    step(2);  // edge 53, digit 1

    #2 rst_n = 1'b0;
    #1;
    chk("arst_an",  32'(bus.an_n), 32'hF);
    chk("arst_seg", 32'(bus.seg_n), 32'h7F);
    chk("arst_dp",  32'(bus.dp_n), 32'h1);
    chk("arst_idx", 32'(bus.digit_idx), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step(1);
    chk("rel_an",  32'(bus.an_n), 32'b1110);
    chk("rel_seg", 32'(bus.seg_n), 32'b0000001);

    #2 rst_n = 1'b0;
    bus.code_in = 16'h0007; bus.gray_mode = 1'b0; bus.load = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step(1);  // release edge with load
    bus.load = 1'b0;
    chk("relld_seg", 32'(bus.seg_n), 32'b0001111);
    chk("relld_an",  32'(bus.an_n), 32'b1110);
    step(4);  // digit 1
    chk("relld_an1", 32'(bus.an_n), 32'b1101);
    chk("relld_d1",  32'(bus.seg_n), 32'(LZ_SEG));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
